// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-to-parallel comma aligner: FSM encoding,
// default comma pattern and output FIFO depth.
package sipo_pkg;

   typedef enum logic [1:0] {
      ST_HUNT    = 2'd0,
      ST_CONFIRM = 2'd1,
      ST_LOCKED  = 2'd2
   } align_state_t;

   localparam logic [9:0] COMMA_DEFAULT = 10'b0011111010;
   localparam int         FIFO_DEPTH    = 2;

endpackage

// File: rtl/sipo_out_fifo.sv
// Small output FIFO with valid/ready pop side and a sticky overflow flag.
// A push into a full FIFO only lands if the head is popped in the same cycle.
module sipo_out_fifo
   import sipo_pkg::*;
#(
   parameter int WIDTH = 10
) (
   input  logic             CLK_IN,
   input  logic             RESET_IN,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_word_i,
   input  logic             push_comma_i,
   input  logic             ready_i,
   input  logic             clear_i,
   output logic [WIDTH-1:0] word_o,
   output logic             comma_o,
   output logic             valid_o,
   output logic             overflow_o
);

   localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNTW = $clog2(FIFO_DEPTH + 1);

   logic [WIDTH-1:0]      word_q [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] comma_q;
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CNTW-1:0]       count_q, count_d;
   logic                  ovf_q, ovf_d;
   logic                  valid, full, pop, push_ok, drop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      valid    = (count_q != '0);
      full     = (count_q == CNTW'(FIFO_DEPTH));
      pop      = valid & ready_i;
      push_ok  = push_i & (~full | pop);
      drop     = push_i & full & ~pop;
      wr_ptr_d = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      count_d  = count_q;
      if (push_ok && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push_ok) begin
         count_d = count_q - 1'b1;
      end
      // A fresh drop outranks a clear arriving in the same cycle.
      ovf_d = (ovf_q & ~clear_i) | drop;
   end

   always_ff @(posedge CLK_IN or posedge RESET_IN) begin
      if (RESET_IN) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            word_q[i] <= '0;
         end
         comma_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (push_ok) begin
            word_q[wr_ptr_q]  <= push_word_i;
            comma_q[wr_ptr_q] <= push_comma_i;
         end
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   assign valid_o    = valid;
   assign word_o     = valid ? word_q[rd_ptr_q] : '0;
   assign comma_o    = valid ? comma_q[rd_ptr_q] : 1'b0;
   assign overflow_o = ovf_q;

endmodule

// File: rtl/sipo_align_ctrl.sv
// Serial-to-parallel deserialiser that hunts for a comma, confirms word
// alignment over several commas, then forwards aligned words to a FIFO.
//
//   state      | meaning
//   -----------+------------------------------------------------------------
//   ST_HUNT    | no alignment; any bit cycle whose candidate is COMMA aligns
//   ST_CONFIRM | aligned; counting consecutive commas at word boundaries
//   ST_LOCKED  | locked; every boundary word pushed, comma gap supervised
module sipo_align_ctrl
   import sipo_pkg::*;
#(
   parameter int               WIDTH      = 10,
   parameter logic [WIDTH-1:0] COMMA      = COMMA_DEFAULT,
   parameter int               LOCK_COUNT = 3,
   parameter int               MAX_GAP    = 64
) (
   input  logic             CLK_IN,
   input  logic             RESET_IN,
   input  logic             ENABLE_IN,
   input  logic             SERIAL_IN,
   input  logic             CLEAR_IN,
   input  logic             WORD_READY_IN,
   output logic [WIDTH-1:0] WORD_OUT,
   output logic             WORD_VALID_OUT,
   output logic             IS_COMMA_OUT,
   output logic             LOCKED_OUT,
   output logic             OVERFLOW_OUT
);

   localparam int CW = $clog2(WIDTH);
   localparam int MW = $clog2(LOCK_COUNT + 1);
   localparam int GW = $clog2(MAX_GAP + 2);

   align_state_t     state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [MW-1:0]    match_q, match_d;
   logic [GW-1:0]    gap_q, gap_d;
   logic [WIDTH-1:0] candidate;
   logic             cand_is_comma;
   logic             boundary;
   logic             push;

   always_ff @(posedge CLK_IN or posedge RESET_IN) begin
      if (RESET_IN) begin
         state_q   <= ST_HUNT;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         match_q   <= '0;
         gap_q     <= '0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         match_q   <= match_d;
         gap_q     <= gap_d;
      end
   end

   always_comb begin
      candidate     = {SERIAL_IN, shift_q[WIDTH-1:1]};
      cand_is_comma = (candidate == COMMA);
      boundary      = (bit_cnt_q == CW'(WIDTH - 1));
      state_d       = state_q;
      shift_d       = shift_q;
      bit_cnt_d     = bit_cnt_q;
      match_d       = match_q;
      gap_d         = gap_q;
      push          = 1'b0;

      if (ENABLE_IN) begin
         shift_d   = candidate;
         bit_cnt_d = boundary ? '0 : bit_cnt_q + 1'b1;
         unique case (state_q)
            ST_HUNT: begin
               // The comma just completed, so the next bit starts a word.
               if (cand_is_comma) begin
                  bit_cnt_d = '0;
                  match_d   = MW'(1);
                  gap_d     = '0;
                  state_d   = (LOCK_COUNT <= 1) ? ST_LOCKED : ST_CONFIRM;
               end
            end
            ST_CONFIRM: begin
               if (boundary) begin
                  if (cand_is_comma) begin
                     match_d = match_q + 1'b1;
                     if (int'(match_q) + 1 >= LOCK_COUNT) begin
                        state_d = ST_LOCKED;
                        gap_d   = '0;
                     end
                  end else begin
                     state_d = ST_HUNT;
                  end
               end
            end
            ST_LOCKED: begin
               if (boundary) begin
                  push = 1'b1;
                  if (cand_is_comma) begin
                     gap_d = '0;
                  end else if (gap_q >= GW'(MAX_GAP)) begin
                     state_d = ST_HUNT;
                  end else begin
                     gap_d = gap_q + 1'b1;
                  end
               end
            end
            default: state_d = ST_HUNT;
         endcase
      end
   end

   sipo_out_fifo #(
      .WIDTH (WIDTH)
   ) u_out_fifo (
      .CLK_IN       (CLK_IN),
      .RESET_IN     (RESET_IN),
      .push_i       (push),
      .push_word_i  (candidate),
      .push_comma_i (cand_is_comma),
      .ready_i      (WORD_READY_IN),
      .clear_i      (CLEAR_IN),
      .word_o       (WORD_OUT),
      .comma_o      (IS_COMMA_OUT),
      .valid_o      (WORD_VALID_OUT),
      .overflow_o   (OVERFLOW_OUT)
   );

   assign LOCKED_OUT = (state_q == ST_LOCKED);

endmodule

// File: doc/sipo_align_ctrl.md
SIPO_ALIGN_CTRL -- requirements
Module: sipo_align_ctrl

Interface
REQ-001 Parameter WIDTH, default 10: deserialised word width in bits.
REQ-002 Parameter COMMA, default 10'b0011111010: alignment pattern, compared LSB-first.
REQ-003 Parameter LOCK_COUNT, default 3: consecutive aligned commas required for lock, counting the first.
REQ-004 Parameter MAX_GAP, default 64: maximum words between commas while locked.
REQ-005 CLK_IN  input  1  clock; all state changes on rising edge.
REQ-006 RESET_IN  input  1  reset, asynchronous, active-high.
REQ-007 ENABLE_IN  input  1  bit-valid qualifier; a cycle with it high is a "bit cycle".
REQ-008 SERIAL_IN  input  1  serial data, LSB first.
REQ-009 CLEAR_IN  input  1  synchronous clear of OVERFLOW_OUT.
REQ-010 WORD_READY_IN  input  1  downstream accepts the head word.
REQ-011 WORD_OUT  output  WIDTH  head word of output FIFO.
REQ-012 WORD_VALID_OUT  output  1  WORD_OUT valid.
REQ-013 IS_COMMA_OUT  output  1  head word equals COMMA.
REQ-014 LOCKED_OUT  output  1  high in state LOCKED.
REQ-015 OVERFLOW_OUT  output  1  sticky; a word was dropped.

Function
REQ-016 Each bit cycle shall load shift_reg with candidate = {SERIAL_IN, shift_reg[WIDTH-1:1]}; other cycles hold all state except FIFO handshake and CLEAR_IN.
REQ-017 Bit counter shall count 0..WIDTH-1 on bit cycles, wrapping to 0; a bit cycle with counter = WIDTH-1 is a "boundary".
REQ-018 States shall be HUNT, CONFIRM, LOCKED; HUNT after reset.
REQ-019 HUNT: on any bit cycle with candidate = COMMA, counter <= 0, match count <= 1, go CONFIRM; boundaries ignored.
REQ-020 CONFIRM: at a boundary with candidate = COMMA, match count increments; on reaching LOCK_COUNT go LOCKED with gap count <= 0.
REQ-021 CONFIRM: at a boundary with candidate != COMMA, go HUNT; same-cycle re-hunt not performed.
REQ-022 LOCKED: each boundary pushes candidate into FIFO with comma flag; gap count resets to 0 on comma, else increments.
REQ-023 LOCKED: boundary where gap count would exceed MAX_GAP shall go HUNT; that word is still pushed.
REQ-024 Words shall be forwarded only in LOCKED; CONFIRM words are discarded.
REQ-025 Output FIFO shall be 2 entries; WORD_VALID_OUT asserts the cycle after a push into empty FIFO (latency 1 from boundary edge).
REQ-026 Pop when WORD_VALID_OUT and WORD_READY_IN both high; WORD_OUT/IS_COMMA_OUT stable while valid and not popped.
REQ-027 Push and pop in the same cycle when full shall both succeed (no drop).
REQ-028 Push when full without pop shall drop the new word and set OVERFLOW_OUT.
REQ-029 CLEAR_IN shall clear OVERFLOW_OUT; simultaneous new overflow wins (stays 1).
REQ-030 ENABLE_IN low shall not affect FIFO handshake.

Reset
REQ-031 RESET_IN shall asynchronously set state HUNT, shift_reg, counters and FIFO to 0, and all outputs to 0.
REQ-032 Reset mid-word or mid-lock shall discard all buffered words; no partial word emitted after release.

Structure
REQ-033 State encoding, default COMMA constant and FIFO depth shall reside in shared package sipo_pkg.
REQ-034 The 2-entry FIFO shall be sub-module sipo_out_fifo; alignment FSM and shifter in top level.

Verification
REQ-035 Commas at 10-bit period from arbitrary bit offset 3 -> LOCKED_OUT high one cycle after third comma boundary; first data word 0x155 emitted with IS_COMMA_OUT=0.
REQ-036 In CONFIRM, second boundary word 0x2AA -> state HUNT, LOCKED_OUT stays 0, no words emitted.
REQ-037 Locked, 65 non-comma words -> LOCKED_OUT falls after boundary of word 65; all 65 words pushed.
REQ-038 WORD_READY_IN low for 3 boundaries -> first 2 words held in order, third dropped, OVERFLOW_OUT=1; CLEAR_IN pulse -> 0.
REQ-039 FIFO full, WORD_READY_IN high at boundary -> pop and push same cycle, no overflow.
REQ-040 RESET_IN pulse mid-word while locked with 2 buffered words -> all outputs 0 immediately; relock needs 3 new commas.
